// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA timing generator: 640x480@60 defaults and counter width.
package vga_timing_pkg;

    localparam int HV_W = 11;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_PIX_DIV   = 2;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int HV_MAX = (1 << HV_W) - 1;

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate divider: pix_tick is high for the one clk in which the divider sits at PIX_DIV-1.
module pix_tick_gen #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

    // pix_tick is decoded from the next divider value so it lines up with the divider itself
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else begin
            div_cnt  <= div_next;
            pix_tick <= (div_next == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: hcount/vcount, blank, hsync/vsync, pix_tick and frame_tick.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int PIX_DIV   = DEF_PIX_DIV
) (
    input  logic            clk,
    input  logic            rst,
    output logic [HV_W-1:0] hcount,
    output logic [HV_W-1:0] vcount,
    output logic            blank,
    output logic            hsync,
    output logic            vsync,
    output logic            pix_tick,
    output logic            frame_tick,
    output logic [15:0]     frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > HV_MAX || V_TOTAL > HV_MAX || PIX_DIV < 1) begin : g_bad_params
            $error("vga_timing_gen: totals must fit in %0d bits and PIX_DIV must be >= 1", HV_W);
        end
    endgenerate

    localparam logic [HV_W-1:0] H_LAST   = HV_W'(H_TOTAL - 1);
    localparam logic [HV_W-1:0] V_LAST   = HV_W'(V_TOTAL - 1);
    localparam logic [HV_W-1:0] H_VIS    = HV_W'(H_VISIBLE);
    localparam logic [HV_W-1:0] V_VIS    = HV_W'(V_VISIBLE);
    localparam logic [HV_W-1:0] HS_START = HV_W'(H_VISIBLE + H_FP);
    localparam logic [HV_W-1:0] HS_END   = HV_W'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [HV_W-1:0] VS_START = HV_W'(V_VISIBLE + V_FP);
    localparam logic [HV_W-1:0] VS_END   = HV_W'(V_VISIBLE + V_FP + V_SYNC);

    logic [HV_W-1:0] h_next;
    logic [HV_W-1:0] v_next;
    logic            wrap;

    pix_tick_gen #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick)
    );

    always_comb begin
        h_next = hcount;
        v_next = vcount;
        wrap   = 1'b0;
        if (pix_tick) begin
            if (hcount == H_LAST) begin
                h_next = '0;
                if (vcount == V_LAST) begin
                    v_next = '0;
                    wrap   = 1'b1;
                end else begin
                    v_next = vcount + HV_W'(1);
                end
            end else begin
                h_next = hcount + HV_W'(1);
            end
        end
    end

    // Decode from the next counter values so blank/sync change on the same edge as the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount     <= '0;
            vcount     <= '0;
            blank      <= 1'b0;
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            hcount     <= h_next;
            vcount     <= v_next;
            blank      <= (h_next >= H_VIS) || (v_next >= V_VIS);
            hsync      <= !((h_next >= HS_START) && (h_next < HS_END));
            vsync      <= !((v_next >= VS_START) && (v_next < VS_END));
            frame_tick <= wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster timing consumed by every pixel-overlay block in the game: hcount, vcount, blank, hsync and vsync.
- Drives the VGA connector directly with hsync/vsync; the overlay blocks take hcount/vcount/blank.
- Also produces a one-cycle frame_tick for game logic that must update once per frame.
- Default timing is 640x480@60 from a 50 MHz board clock, giving a 25 MHz pixel rate.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel; must be >= 1

Ports:
- clk  input  1  board clock
- rst  input  1  asynchronous active-low reset
- hcount  output  11  current pixel column, 0..H_TOTAL-1
- vcount  output  11  current line, 0..V_TOTAL-1
- blank  output  1  1 when (hcount,vcount) is outside the visible area
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- pix_tick  output  1  one-clk pulse on each pixel advance
- frame_tick  output  1  one-clk pulse when the raster wraps to (0,0)
- frame_count  output  16  frame counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Reset values: hcount=0, vcount=0, blank=0, hsync=1, vsync=1, pix_tick=0, frame_tick=0, frame_count=0, divider=0.
- Divider: counts 0..PIX_DIV-1 and wraps. pix_tick is registered and high for exactly the one clk in which the divider equals PIX_DIV-1. With PIX_DIV=1, pix_tick is constantly 1 after reset.
- Counter advance: on every clk where the divider equals PIX_DIV-1:
  - if hcount == H_TOTAL-1: hcount <= 0, and vcount <= (vcount == V_TOTAL-1) ? 0 : vcount+1;
  - otherwise hcount <= hcount+1.
- Counters hold on all other cycles.
- Registered decode: blank, hsync and vsync are registers computed from the NEXT counter values, so they change on the same edge as hcount/vcount. There is zero cycle skew between counters and decode; consumers may compare hcount/vcount and blank on the same cycle.
- blank = (h >= H_VISIBLE) || (v >= V_VISIBLE).
- hsync = 0 iff H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC (656..751).
- vsync = 0 iff V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC (490..491); vsync is evaluated per line, independent of h.
- frame_tick: high for exactly one clk, on the edge where the counters become (0,0) through wrap. It is NOT asserted by reset.
- Reset mid-frame: all outputs return immediately to their reset values. The raster restarts at (0,0) visible; no partial-frame frame_tick is emitted.
- Widths: 11 bits covers H_TOTAL up to 2047. Parameter combinations exceeding that are illegal and are flagged by an elaboration-time check.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: frame_count increments by 1 (mod 2^16) on every frame_tick and resets to 0.
- Undefined: frame_count is tied to 16'd0, and the counter flops are not instantiated.
- The port exists in both builds.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480@60 default constants (H_/V_ visible, porch and sync values);
  - derived H_TOTAL/V_TOTAL;
  - HV_W=11 counter width.
- One natural sub-module: pix_tick_gen, holding the PIX_DIV divider and pix_tick register. It is instantiated once; the raster counters and sync decode stay in the top.

Test Plan:
- Reset release, PIX_DIV=2: pix_tick pulses every 2nd clk. hcount reads 0,0,1,1,2,...; blank=0, hsync=1, vsync=1 throughout the first 640 pixels.
- Run to hcount 639->640: blank rises on the same edge. hsync falls at hcount=656, rises at hcount=752. At 799->0, vcount increments 0->1.
- Run to vcount 480: blank stays 1 for the whole line. vsync is low exactly for vcount 490 and 491 (all 800 pixels of each line).
- Full frame: the first frame_tick occurs 800*525*2 = 840000 clks after reset release, with hcount=vcount=0. The next occurs exactly 840000 clks later. With VGA_TIMING_FRAME_CNT_EN defined, frame_count reads 1 then 2.
- Reset asserted at (300,200) for 3 clks: outputs are at reset values asynchronously. After release, the raster restarts at (0,0) and no frame_tick appears until 840000 clks later.
- PIX_DIV=1, H_VISIBLE=8/H_FP=2/H_SYNC=2/H_BP=2, V_VISIBLE=4/V_FP=1/V_SYNC=1/V_BP=1: pix_tick is always 1, and hcount wraps every 14 clks. hsync is low for hcount 10..11, vsync low for vcount 5, and frame_tick fires every 98 clks.
